data_mem_arbiter: RTL

- Sits directly downstream of the compute core's per-thread LSU data-memory ports. Arbitrates NUM_CONSUMERS independent read/write request ports onto one shared external data-memory channel.
- Each consumer port uses a valid/ready handshake: the consumer holds valid until ready, then drops valid.
- Fair round-robin grant, one transaction in flight at a time.

---
 rtl/data_mem_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that funnels NUM_CONSUMERS LSU read/write ports onto a
// single external data-memory channel, one transaction in flight at a time.
// Each consumer keeps valid high until it sees ready, then drops valid; the
// arbiter holds ready until that drop is observed before moving on.

module data_mem_arbiter #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,

    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,

    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready
);

    localparam int unsigned IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CONSUMERS - 1);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] READ_WAIT   = 3'd1;
    localparam logic [2:0] WRITE_WAIT  = 3'd2;
    localparam logic [2:0] READ_RELAY  = 3'd3;
    localparam logic [2:0] WRITE_RELAY = 3'd4;

    // Architectural state
    logic [2:0]               state_q, state_d;
    logic [IDX_BITS-1:0]      grant_q, grant_d;
    logic [IDX_BITS-1:0]      rr_ptr_q, rr_ptr_d;

    // Registered outputs
    logic                     mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]     mem_read_address_q, mem_read_address_d;
    logic                     mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]     mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]     mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0] read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS-1:0] write_ready_q, write_ready_d;
    logic [DATA_BITS-1:0]     read_data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     read_data_d [NUM_CONSUMERS];

    // Unpacked views of the flattened per-port buses
    logic [ADDR_BITS-1:0]     rd_addr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     wr_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     wr_data [NUM_CONSUMERS];

    // Round-robin scan results
    logic                     pick_found;
    logic                     pick_read;
    logic [IDX_BITS-1:0]      pick_idx;
    logic [IDX_BITS:0]        scan_sum;
    logic [IDX_BITS-1:0]      scan_idx;

    // Split the flattened request buses into per-port fields
    always_comb begin
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
            wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
            wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Find the first requesting port starting at rr_ptr; read beats write on one port
    always_comb begin
        pick_found = 1'b0;
        pick_read  = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            // rr_ptr < NUM_CONSUMERS, so one conditional subtract is a full modulo
            scan_sum = {1'b0, rr_ptr_q} + (IDX_BITS+1)'(k);
            if (scan_sum >= (IDX_BITS+1)'(NUM_CONSUMERS)) begin
                scan_sum = scan_sum - (IDX_BITS+1)'(NUM_CONSUMERS);
            end
            scan_idx = scan_sum[IDX_BITS-1:0];
            if (!pick_found &&
                (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
                pick_read  = consumer_read_valid[scan_idx];
            end
        end
    end

    // Transaction FSM: grant, wait for memory, relay ready until the consumer drops valid
    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        rr_ptr_d            = rr_ptr_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        read_ready_d        = read_ready_q;
        write_ready_d       = write_ready_q;
        read_data_d         = read_data_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    // Address/data are captured here; later port changes are ignored
                    if (pick_read) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = rd_addr[pick_idx];
                        state_d            = READ_WAIT;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = wr_addr[pick_idx];
                        mem_write_data_d    = wr_data[pick_idx];
                        state_d             = WRITE_WAIT;
                    end
                end
            end

            READ_WAIT: begin
                if (mem_read_ready) begin
                    read_data_d[grant_q]  = mem_read_data;
                    read_ready_d[grant_q] = 1'b1;
                    mem_read_valid_d      = 1'b0;
                    state_d               = READ_RELAY;
                end
            end

            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    write_ready_d[grant_q] = 1'b1;
                    mem_write_valid_d      = 1'b0;
                    state_d                = WRITE_RELAY;
                end
            end

            READ_RELAY: begin
                if (!consumer_read_valid[grant_q]) begin
                    read_ready_d = '0;
                    rr_ptr_d     = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    state_d      = IDLE;
                end
            end

            WRITE_RELAY: begin
                if (!consumer_write_valid[grant_q]) begin
                    write_ready_d = '0;
                    rr_ptr_d      = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d           = IDLE;
                mem_read_valid_d  = 1'b0;
                mem_write_valid_d = 1'b0;
                read_ready_d      = '0;
                write_ready_d     = '0;
            end
        endcase
    end

    // State registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            grant_q             <= '0;
            rr_ptr_q            <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                read_data_q[i] <= '0;
            end
        end else begin
            state_q             <= state_d;
            grant_q             <= grant_d;
            rr_ptr_q            <= rr_ptr_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            read_ready_q        <= read_ready_d;
            write_ready_q       <= write_ready_d;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                read_data_q[i] <= read_data_d[i];
            end
        end
    end

    // Repack per-port read data onto the flattened output bus
    always_comb begin
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            consumer_read_data[i*DATA_BITS +: DATA_BITS] = read_data_q[i];
        end
    end

    assign consumer_read_ready  = read_ready_q;
    assign consumer_write_ready = write_ready_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;

endmodule
